// File: rtl/dds_chirp_gen_if.sv
// Purpose: control/status bundle between the register block and dds_chirp_gen.
// Latency: n/a (wires only).
// Backpressure: none; the sample stream is free-running at one sample per clk.
// Ports: cfg_* / start / stop are driven by the master (register block);
//        dac_* / ftw_mon / busy / sweep_* are driven by the slave (generator).
interface dds_chirp_gen_if #(
  parameter int DAC_BITS   = 12,
  parameter int PHASE_BITS = 32,
  parameter int FRAC_BITS  = 32,
  parameter int LEN_BITS   = 24
);
  localparam int W = PHASE_BITS + FRAC_BITS;

  logic [W-1:0]          cfg_ftw0;
  logic [W-1:0]          cfg_delta;
  logic [LEN_BITS-1:0]   cfg_len;
  logic [LEN_BITS-1:0]   cfg_gap;
  logic [1:0]            cfg_mode;
  logic                  start;
  logic                  stop;
  logic [DAC_BITS-1:0]   dac_data;
  logic                  dac_valid;
  logic [PHASE_BITS-1:0] ftw_mon;
  logic                  busy;
  logic                  sweep_start;
  logic                  sweep_done;

  modport master (
    output cfg_ftw0, cfg_delta, cfg_len, cfg_gap, cfg_mode, start, stop,
    input  dac_data, dac_valid, ftw_mon, busy, sweep_start, sweep_done
  );

  modport slave (
    input  cfg_ftw0, cfg_delta, cfg_len, cfg_gap, cfg_mode, start, stop,
    output dac_data, dac_valid, ftw_mon, busy, sweep_start, sweep_done
  );
endinterface

// File: rtl/dds_chirp_gen.sv
// Purpose: runtime-configurable DDS chirp generator (up/down saw, triangle, single shot).
// Latency: phase registered in cycle t reaches dac_data in cycle t+2 (ROM read + output reg).
// Backpressure: none; one sample per clk, stop flushes the pipeline.
// Ports: clk, rst (async, active-high); bus = dds_chirp_gen_if.slave carrying the
//        cfg_*/start/stop controls and the dac_data/dac_valid/ftw_mon/busy/sweep_* outputs.

// Quarter-free full sine table with one registered read port, offset-binary output.
module sine_rom #(
  parameter int DAC_BITS = 12,
  parameter int LUT_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LUT_BITS-1:0] addr,
  output logic [DAC_BITS-1:0] data
);
  localparam logic [DAC_BITS-1:0] MID = {1'b1, {(DAC_BITS-1){1'b0}}};

  // round() with ties away from zero, then shift into offset-binary.
  function automatic logic [DAC_BITS-1:0] sine_val(input int a);
    real v;
    int  r;
    v = (2.0 ** (DAC_BITS - 1) - 1.0) * $sin(2.0 * 3.14159265358979323846 * a / (2.0 ** LUT_BITS));
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return DAC_BITS'(r + 2 ** (DAC_BITS - 1));
  endfunction

  logic [DAC_BITS-1:0] tbl [2**LUT_BITS];
  for (genvar a = 0; a < 2**LUT_BITS; a++) begin : g_tbl
    assign tbl[a] = sine_val(a);
  end

  logic [DAC_BITS-1:0] data_d, data_q;
  always_comb data_d = tbl[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= MID;
    else     data_q <= data_d;
  end

  assign data = data_q;
endmodule

module dds_chirp_gen #(
  parameter int DAC_BITS   = 12,
  parameter int PHASE_BITS = 32,
  parameter int FRAC_BITS  = 32,
  parameter int LUT_BITS   = 10,
  parameter int LEN_BITS   = 24
) (
  input logic           clk,
  input logic           rst,
  dds_chirp_gen_if.slave bus
);
  localparam int W = PHASE_BITS + FRAC_BITS;
  localparam logic [DAC_BITS-1:0] MID = {1'b1, {(DAC_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SWEEP_UP, SWEEP_DN, GAP} state_t;

  state_t                state_d, state_q;
  logic [W-1:0]          freq_d, freq_q, ftw0_d, ftw0_q, delta_d, delta_q;
  logic [PHASE_BITS-1:0] phase_d, phase_q;
  logic [LEN_BITS-1:0]   cnt_d, cnt_q, len_d, len_q, gap_d, gap_q;
  logic [1:0]            mode_d, mode_q;
  logic                  sweep_start_d, sweep_start_q, sweep_done_d, sweep_done_q;
  logic                  v1_d, v1_q, g1_d, g1_q, dac_valid_d, dac_valid_q;
  logic [DAC_BITS-1:0]   dac_data_d, dac_data_q, rom_data;
  logic [PHASE_BITS-1:0] ftw_mon;
  logic                  enter;

  assign ftw_mon = freq_q[W-1 -: PHASE_BITS];

  sine_rom #(.DAC_BITS(DAC_BITS), .LUT_BITS(LUT_BITS)) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (phase_q[PHASE_BITS-1 -: LUT_BITS]),
    .data (rom_data)
  );

  always_comb begin
    state_d       = state_q;
    freq_d        = freq_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    ftw0_d        = ftw0_q;
    delta_d       = delta_q;
    len_d         = len_q;
    gap_d         = gap_q;
    mode_d        = mode_q;
    sweep_start_d = 1'b0;
    sweep_done_d  = 1'b0;
    enter         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.cfg_len != '0)) begin
          ftw0_d        = bus.cfg_ftw0;
          delta_d       = bus.cfg_delta;
          len_d         = bus.cfg_len;
          gap_d         = bus.cfg_gap;
          mode_d        = bus.cfg_mode;
          state_d       = (bus.cfg_mode == 2'b01) ? SWEEP_DN : SWEEP_UP;
          freq_d        = bus.cfg_ftw0;
          phase_d       = '0;
          cnt_d         = '0;
          sweep_start_d = 1'b1;
        end
      end
      SWEEP_UP, SWEEP_DN: begin
        phase_d = phase_q + ftw_mon;
        freq_d  = (state_q == SWEEP_UP) ? freq_q + delta_q : freq_q - delta_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == len_q - 1'b1) begin
          cnt_d = '0;
          if (mode_q == 2'b11) begin
            state_d      = IDLE;
            sweep_done_d = 1'b1;
          end else if (mode_q == 2'b10 && state_q == SWEEP_UP) begin
            // Triangle turns around in place: freq_acc and phase carry on.
            state_d = SWEEP_DN;
          end else if (gap_q != '0) begin
            state_d = GAP;
          end else begin
            enter = 1'b1;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == gap_q - 1'b1) enter = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (enter) begin
      state_d       = (mode_q == 2'b01) ? SWEEP_DN : SWEEP_UP;
      freq_d        = ftw0_q;
      phase_d       = '0;
      cnt_d         = '0;
      sweep_start_d = 1'b1;
    end

    if (bus.stop) begin
      state_d       = IDLE;
      cnt_d         = '0;
      sweep_start_d = 1'b0;
      sweep_done_d  = 1'b0;
    end

    // Valid and gap flag ride alongside the ROM read so they line up with its data.
    v1_d        = !bus.stop && (state_q != IDLE);
    g1_d        = (state_q == GAP);
    dac_valid_d = !bus.stop && v1_q;
    dac_data_d  = (bus.stop || !v1_q || g1_q) ? MID : rom_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      freq_q        <= '0;
      phase_q       <= '0;
      cnt_q         <= '0;
      ftw0_q        <= '0;
      delta_q       <= '0;
      len_q         <= '0;
      gap_q         <= '0;
      mode_q        <= '0;
      sweep_start_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      v1_q          <= 1'b0;
      g1_q          <= 1'b0;
      dac_valid_q   <= 1'b0;
      dac_data_q    <= MID;
    end else begin
      state_q       <= state_d;
      freq_q        <= freq_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      ftw0_q        <= ftw0_d;
      delta_q       <= delta_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      mode_q        <= mode_d;
      sweep_start_q <= sweep_start_d;
      sweep_done_q  <= sweep_done_d;
      v1_q          <= v1_d;
      g1_q          <= g1_d;
      dac_valid_q   <= dac_valid_d;
      dac_data_q    <= dac_data_d;
    end
  end

  assign bus.dac_data    = dac_data_q;
  assign bus.dac_valid   = dac_valid_q;
  assign bus.ftw_mon     = ftw_mon;
  assign bus.busy        = (state_q != IDLE);
  assign bus.sweep_start = sweep_start_q;
  assign bus.sweep_done  = sweep_done_q;
endmodule

// File: tb/tb_dds_chirp_gen.sv
module tb_dds_chirp_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_chirp_gen_if bus ();
  dds_chirp_gen dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]        mode;
    logic [63:0]       ftw0;
    logic [63:0]       delta;
    logic [23:0]       len;
    logic [23:0]       gap;
    int                n;
    logic [0:15][31:0] ftw;   // expected ftw_mon per cycle after start
    logic [0:15]       ss;    // expected sweep_start per cycle
    logic [0:15]       vm;    // 1 = sweep sample, 0 = gap sample
  } vec_t;

  vec_t        tbl [5];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q [$];
  logic [11:0] got_q [$];
  bit          strict = 1'b0;
  int          sd_cnt = 0;
  int          ss_cnt = 0;
  logic [31:0] ph;

  function automatic logic [11:0] rom_ref(input int a);
    real v;
    int  r;
    v = 2047.0 * $sin(2.0 * 3.14159265358979323846 * a / 1024.0);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return 12'(r + 2048);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic [1:0] mode, input logic [63:0] ftw0,
                         input logic [63:0] delta, input logic [23:0] len, input logic [23:0] gap,
                         input int n, input logic [0:15] ss, input logic [0:15] vm);
    tbl[i].mode = mode; tbl[i].ftw0 = ftw0; tbl[i].delta = delta;
    tbl[i].len = len; tbl[i].gap = gap; tbl[i].n = n; tbl[i].ss = ss; tbl[i].vm = vm;
  endtask

  task automatic start_pulse(input logic [1:0] mode, input logic [63:0] ftw0,
                             input logic [63:0] delta, input logic [23:0] len, input logic [23:0] gap);
    @(posedge clk); #1;
    bus.cfg_mode = mode; bus.cfg_ftw0 = ftw0; bus.cfg_delta = delta;
    bus.cfg_len = len; bus.cfg_gap = gap; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic stop_pulse();
    @(posedge clk); #1 bus.stop = 1'b1;
    @(posedge clk); #1 bus.stop = 1'b0;
  endtask

  // Scoreboard consumer: every valid DAC sample pops one expected value.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sweep_done)  sd_cnt++;
      if (bus.sweep_start) ss_cnt++;
      if (bus.dac_valid) begin
        got_q.push_back(bus.dac_data);
        if (exp_q.size() > 0) chk("dac_data", 64'(bus.dac_data), 64'(exp_q.pop_front()));
        else if (strict) begin
          checks++;
          errors++;
          $display("FAIL extra_sample: got valid sample %0h, required none", bus.dac_data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_row(0, 2'b00, 64'd0, 64'h1_0000_0000, 24'd4, 24'd2, 14,
            16'b1000_0010_0000_1000, 16'b1111_0011_1100_1100);
    tbl[0].ftw = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd1,
                  32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
    set_row(1, 2'b00, 64'h0400_0000_0000_0000, 64'h0100_0000_0000_0000, 24'd5, 24'd1, 12,
            16'b1000_0010_0000_0000, 16'b1111_1011_1110_0000);
    tbl[1].ftw = {32'h0400_0000, 32'h0500_0000, 32'h0600_0000, 32'h0700_0000, 32'h0800_0000, 32'd0,
                  32'h0400_0000, 32'h0500_0000, 32'h0600_0000, 32'h0700_0000, 32'h0800_0000, 32'd0,
                  32'd0, 32'd0, 32'd0, 32'd0};
    set_row(2, 2'b10, 64'd0, 64'h1_0000_0000, 24'd4, 24'd0, 12,
            16'b1000_0000_1000_0000, 16'hFFF0);
    tbl[2].ftw = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd3, 32'd2, 32'd1,
                  32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0};
    set_row(3, 2'b01, 64'd0, 64'h1_0000_0000, 24'd3, 24'd0, 9,
            16'b1001_0010_0000_0000, 16'hFF80);
    tbl[3].ftw = {32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                  32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    set_row(4, 2'b10, 64'h1000_0000_0000_0000, 64'h0400_0000_0000_0000, 24'd2, 24'd1, 10,
            16'b1000_0100_0000_0000, 16'b1111_0111_1000_0000);
    tbl[4].ftw = {32'h1000_0000, 32'h1400_0000, 32'h1800_0000, 32'h1400_0000, 32'd0,
                  32'h1000_0000, 32'h1400_0000, 32'h1800_0000, 32'h1400_0000, 32'd0,
                  32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    rst = 1'b1;
    bus.cfg_ftw0 = '0; bus.cfg_delta = '0; bus.cfg_len = '0; bus.cfg_gap = '0;
    bus.cfg_mode = '0; bus.start = 1'b0; bus.stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac_data", 64'(bus.dac_data), 64'h800);
    chk("rst_dac_valid", 64'(bus.dac_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ftw_mon", 64'(bus.ftw_mon), 64'd0);
    chk("rst_pulses", 64'({bus.sweep_start, bus.sweep_done}), 64'd0);
    rst = 1'b0;

    // Table-driven repeating sweeps: ftw_mon / sweep_start per cycle, DAC via scoreboard.
    for (int i = 0; i < 5; i++) begin
      ph = '0;
      for (int c = 0; c < tbl[i].n; c++) begin
        if (tbl[i].ss[c]) ph = '0;
        if (tbl[i].vm[c]) begin
          exp_q.push_back(rom_ref(int'(ph[31:22])));
          ph = ph + tbl[i].ftw[c];
        end else exp_q.push_back(12'h800);
      end
      start_pulse(tbl[i].mode, tbl[i].ftw0, tbl[i].delta, tbl[i].len, tbl[i].gap);
      for (int c = 0; c < tbl[i].n; c++) begin
        @(negedge clk);
        if (tbl[i].vm[c]) chk($sformatf("v%0d_ftw_c%0d", i, c), 64'(bus.ftw_mon), 64'(tbl[i].ftw[c]));
        chk($sformatf("v%0d_sweep_start_c%0d", i, c), 64'(bus.sweep_start), 64'(tbl[i].ss[c]));
      end
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      chk($sformatf("v%0d_drain", i), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      stop_pulse();
      @(negedge clk);
      chk($sformatf("v%0d_stop_busy", i), 64'(bus.busy), 64'd0);
      chk($sformatf("v%0d_stop_valid", i), 64'(bus.dac_valid), 64'd0);
    end

    // Single shot: exactly 16 samples at fs/16, one sweep_done, then idle.
    repeat (3) @(negedge clk);
    got_q.delete(); sd_cnt = 0; ss_cnt = 0; strict = 1'b1;
    ph = '0;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(rom_ref(int'(ph[31:22])));
      ph = ph + 32'h1000_0000;
    end
    start_pulse(2'b11, 64'h1000_0000_0000_0000, 64'd0, 24'd16, 24'd0);
    repeat (24) @(negedge clk);
    chk("single_count", 64'(got_q.size()), 64'd16);
    chk("single_s0", 64'(got_q[0]), 64'h800);
    chk("single_s4", 64'(got_q[4]), 64'hFFF);
    chk("single_s8", 64'(got_q[8]), 64'h800);
    chk("single_s12", 64'(got_q[12]), 64'h001);
    chk("single_done_cnt", 64'(sd_cnt), 64'd1);
    chk("single_busy_after", 64'(bus.busy), 64'd0);
    chk("single_drain", 64'(exp_q.size()), 64'd0);

    // Start (with new cfg) while busy is ignored; the single sweep finishes unchanged.
    got_q.delete(); exp_q.delete(); sd_cnt = 0; ss_cnt = 0;
    ph = '0;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(rom_ref(int'(ph[31:22])));
      ph = ph + 32'h1000_0000;
    end
    start_pulse(2'b11, 64'h1000_0000_0000_0000, 64'd0, 24'd16, 24'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.cfg_mode = 2'b00; bus.cfg_len = 24'd4; bus.cfg_ftw0 = 64'h0800_0000_0000_0000; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (24) @(negedge clk);
    chk("busy_start_count", 64'(got_q.size()), 64'd16);
    chk("busy_start_ss_cnt", 64'(ss_cnt), 64'd1);
    chk("busy_start_done_cnt", 64'(sd_cnt), 64'd1);
    chk("busy_start_idle", 64'(bus.busy), 64'd0);
    strict = 1'b0; exp_q.delete();

    // Stop at sample 5 of a long sweep.
    start_pulse(2'b00, 64'h1000_0000_0000_0000, 64'h0100_0000_0000_0000, 24'd100, 24'd0);
    sd_cnt = 0;
    repeat (5) @(posedge clk);
    #1 bus.stop = 1'b1;
    @(posedge clk); #1 bus.stop = 1'b0;
    got_q.delete();
    @(negedge clk);
    chk("stop_busy", 64'(bus.busy), 64'd0);
    chk("stop_valid", 64'(bus.dac_valid), 64'd0);
    chk("stop_data", 64'(bus.dac_data), 64'h800);
    repeat (5) @(negedge clk);
    chk("stop_no_done", 64'(sd_cnt), 64'd0);
    chk("stop_no_samples", 64'(got_q.size()), 64'd0);

    // start+stop together from IDLE, then start with len 0: both stay idle.
    ss_cnt = 0;
    @(posedge clk); #1;
    bus.cfg_mode = 2'b00; bus.cfg_len = 24'd8; bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("start_stop_busy", 64'(bus.busy), 64'd0);
    chk("start_stop_ss", 64'(ss_cnt), 64'd0);
    start_pulse(2'b00, 64'h1000_0000_0000_0000, 64'd0, 24'd0, 24'd0);
    repeat (4) @(negedge clk);
    chk("len0_busy", 64'(bus.busy), 64'd0);
    chk("len0_ss", 64'(ss_cnt), 64'd0);

    // Asynchronous reset in the middle of a sweep.
    start_pulse(2'b00, 64'h1000_0000_0000_0000, 64'h0100_0000_0000_0000, 24'd100, 24'd0);
    repeat (10) @(negedge clk);
    chk("pre_rst_valid", 64'(bus.dac_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dac_data", 64'(bus.dac_data), 64'h800);
    chk("arst_valid", 64'(bus.dac_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_ftw_mon", 64'(bus.ftw_mon), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    ss_cnt = 0; sd_cnt = 0; got_q.delete();
    repeat (6) @(negedge clk);
    chk("post_rst_pulses", 64'(ss_cnt + sd_cnt), 64'd0);
    chk("post_rst_samples", 64'(got_q.size()), 64'd0);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_chirp_gen.md
Name: dds_chirp_gen

Overview:
- Runtime-configurable DDS chirp generator; parametrised successor of the fixed-constant chirp top.
- Start frequency, sweep rate, sweep length, inter-sweep gap and sweep mode are latched from ports at start.
- Mode is one of up-saw, down-saw, triangle or single-shot; repetition and stop are under FSM control.
- Sits between the control/register block and the DAC interface; reuses the existing sine_rom.

Parameters:
- DAC_BITS, 12, DAC sample width, offset-binary.
- PHASE_BITS, 32, phase accumulator and FTW width.
- FRAC_BITS, 32, fractional bits of the frequency accumulator; W = PHASE_BITS+FRAC_BITS.
- LUT_BITS, 10, sine ROM address width.
- LEN_BITS, 24, width of the sweep-length and gap counters.

Ports:
- clk  in  1  system/sample clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_ftw0  in  W  start value of the frequency accumulator.
- cfg_delta  in  W  unsigned per-sample frequency step, in accumulator units.
- cfg_len  in  LEN_BITS  samples per sweep (half-sweep in triangle mode).
- cfg_gap  in  LEN_BITS  idle samples between sweeps; 0 means back-to-back sweeps.
- cfg_mode  in  2  00 up-saw, 01 down-saw, 10 triangle, 11 single up-sweep.
- start  in  1  one-cycle start pulse.
- stop  in  1  one-cycle abort pulse.
- dac_data  out  DAC_BITS  sine sample.
- dac_valid  out  1  dac_data carries a sweep or gap sample.
- ftw_mon  out  PHASE_BITS  FTW currently applied (freq_acc[W-1:FRAC_BITS]).
- busy  out  1  FSM not IDLE.
- sweep_start  out  1  pulse on the first sample of each sweep.
- sweep_done  out  1  pulse on the cycle the FSM returns to IDLE after single mode.

Behaviour:
- Reset (async): FSM=IDLE, freq_acc=0, phase=0, counters=0, dac_data=2^(DAC_BITS-1) (0x800), dac_valid=0, ftw_mon=0, busy=0, pulses=0.
- FSM states: IDLE, SWEEP_UP, SWEEP_DN, GAP.
- IDLE to sweep: on start with cfg_len!=0, latch all cfg_*; go to SWEEP_UP (modes 00/10/11) or SWEEP_DN (01).
- A start with cfg_len==0 is ignored; a start while busy is ignored.
- Sweep entry: freq_acc=ftw0, phase=0, sample counter=0; sweep_start is asserted on the first sweep cycle.
- SWEEP_UP: per cycle, phase += ftw_mon and freq_acc += delta.
- SWEEP_DN: per cycle, phase += ftw_mon and freq_acc -= delta.
- Arithmetic: all wrap modulo 2^W (freq_acc) or 2^PHASE_BITS (phase); no saturation.
- Sample k of an up sweep uses FTW (ftw0 + k*delta)>>FRAC_BITS.
- Sweep end: after cfg_len samples, the next state is chosen as follows.
  - Single mode: go to IDLE and pulse sweep_done.
  - Triangle, from SWEEP_UP: go to SWEEP_DN without resetting freq_acc or phase, so down sample k uses ftw0+(len-k)*delta.
  - Triangle from SWEEP_DN, or saw modes: go to GAP if gap!=0, otherwise directly to the next sweep entry.
- GAP: run for cfg_gap cycles, then sweep entry. phase and freq_acc are held; the gap sample value is midscale.
- Pipeline: ROM address = phase[PHASE_BITS-1 -: LUT_BITS]; sine_rom has a registered read.
  - The sample whose phase is registered in cycle t appears on dac_data in cycle t+2.
  - dac_valid and the midscale substitution for gap samples travel through the same 2-stage pipeline.
  - dac_valid falls 2 cycles after the last sample.
- ROM contents: round((2^(DAC_BITS-1)-1)*sin(2*pi*a/2^LUT_BITS)) + 2^(DAC_BITS-1).
- stop (any state): next cycle FSM=IDLE, pipeline flushed, dac_data=midscale, dac_valid=0, busy=0, no sweep_done.
- start and stop in the same cycle: stop wins.
- cfg_* changes while busy have no effect until the next start.

Test Plan:
- Reset asserted mid-sweep -> dac_data=0x800, dac_valid=0, busy=0, ftw_mon=0 immediately (async); no pulses after release.
- Single mode, ftw0=2^60, delta=0, len=16 -> exactly 16 valid samples (period fs/16).
  - Samples 0, 4, 8 and 12 are 0x800, 0xFFF, 0x800 and 0x001.
  - sweep_done pulses once; busy then drops.
- Up-saw, ftw0=0, delta=2^32, len=4, gap=2 -> ftw_mon repeats 0,1,2,3,(gap),0,1,2,3.
  - sweep_start pulses every 6 cycles.
  - dac_valid is continuous with gap samples at 0x800.
- Triangle, same step, len=4, gap=0 -> ftw_mon sequence 0,1,2,3,4,3,2,1,0,1,…; sweep_start only at each up-half entry.
- Down-saw, ftw0=0, delta=2^32, len=3 -> ftw_mon repeats 0, 0xFFFFFFFF, 0xFFFFFFFE (wrap).
- Stop at sample 5 of len=100 -> IDLE next cycle, dac_valid low, no sweep_done.
  - start+stop in the same cycle from IDLE -> stays IDLE.
  - start while busy -> ignored.
  - start with cfg_len=0 -> ignored.
